// File: rtl/fifo_ctrl_wrap_ptr.sv
// wrap_ptr: modulo-DEPTH pointer register for the circular FIFO controller.
// The pointer advances by one on inc and wraps from DEPTH-1 to 0. It uses
// exactly ADDR_WIDTH bits, so the wrap is the register's natural overflow.
//   clk      in   system clock, rising edge
//   reset_n  in   synchronous active-low reset (priority over clr)
//   clr      in   synchronous flush to 0
//   inc      in   advance pointer by one
//   ptr      out  current pointer value
module wrap_ptr #(
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] ptr
);

  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and status controller for a circular FIFO placed
// directly upstream of reg_file. Drives reg_file wr_en/wr_addr/rd_addr from
// push/pop requests and reports occupancy, thresholds and sticky errors.
//   clk          in   system clock, rising edge
//   reset_n      in   synchronous active-low reset (priority over clr)
//   clr          in   synchronous flush, same effect as reset
//   push, pop    in   producer write / consumer read requests
//   wr_en        out  reg_file write enable (accepted push)
//   wr_addr      out  write pointer
//   rd_addr      out  read pointer (head entry)
//   full, empty  out  count == DEPTH / count == 0
//   almost_full  out  count >= AF_LEVEL
//   almost_empty out  count <= AE_LEVEL
//   count        out  occupancy 0..DEPTH
//   overflow     out  sticky, set by a push while full
//   underflow    out  sticky, set by a pop while empty
module fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned AF_LEVEL   = 2**ADDR_WIDTH - 1,
  parameter int unsigned AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);

  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic                push_ok, pop_ok;
  logic                active;

  // Status decodes from count only; pointer equality is ambiguous at full/empty.
  assign full         = (count_q == DEPTH_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);

  // Requests are ignored during reset/clr so neither pointer nor storage moves.
  assign active  = reset_n & ~clr;
  assign push_ok = push & ~full & active;
  assign pop_ok  = pop & ~empty & active;
  assign wr_en   = push_ok;

  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q | (push & full);
    underflow_d = underflow_q | (pop & empty);
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_ONE;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_ONE;
    end
    if (clr) begin
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  wrap_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .inc     (push_ok),
    .ptr     (wr_addr)
  );

  wrap_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .inc     (pop_ok),
    .ptr     (rd_addr)
  );

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl. Two instances share stimulus: the default
// thresholds (AF=3, AE=1) and AF=2/AE=2. A behavioural byte array stands in
// for reg_file; a queue-based FIFO model predicts every cycle's outputs.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset_n, clr, push, pop;
  logic [7:0] wr_data;

  logic       wr_en_a, full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
  logic [1:0] wa_a, ra_a;
  logic [2:0] cnt_a;
  logic       wr_en_b, full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
  logic [1:0] wa_b, ra_b;
  logic [2:0] cnt_b;

  always #5 clk = ~clk;

  fifo_ctrl #(.ADDR_WIDTH(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .clr(clr), .push(push), .pop(pop),
    .wr_en(wr_en_a), .wr_addr(wa_a), .rd_addr(ra_a), .full(full_a),
    .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a), .count(cnt_a),
    .overflow(ovf_a), .underflow(unf_a)
  );

  fifo_ctrl #(.ADDR_WIDTH(2), .AF_LEVEL(2), .AE_LEVEL(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .clr(clr), .push(push), .pop(pop),
    .wr_en(wr_en_b), .wr_addr(wa_b), .rd_addr(ra_b), .full(full_b),
    .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b), .count(cnt_b),
    .overflow(ovf_b), .underflow(unf_b)
  );

  // reg_file stand-in: synchronous write, combinational read
  logic [7:0] mem [4];
  logic [7:0] rd_data;
  always @(posedge clk) if (wr_en_a) mem[wa_a] <= wr_data;
  assign rd_data = mem[ra_a];

  typedef struct {
    bit         chk;
    bit         pchk;
    logic [7:0] pdata;
    logic       wr_en;
    logic [1:0] wa, ra;
    int         cnt;
    logic       full, empty, ovf, unf;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  // Monitor: one record per cycle, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk) begin
        check("wr_en",     32'(wr_en_a), 32'(e.wr_en));
        check("wr_en_b",   32'(wr_en_b), 32'(e.wr_en));
        check("wr_addr",   32'(wa_a),    32'(e.wa));
        check("rd_addr",   32'(ra_a),    32'(e.ra));
        check("count",     32'(cnt_a),   32'(e.cnt));
        check("count_b",   32'(cnt_b),   32'(e.cnt));
        check("full",      32'(full_a),  32'(e.full));
        check("empty",     32'(empty_a), 32'(e.empty));
        check("overflow",  32'(ovf_a),   32'(e.ovf));
        check("underflow", 32'(unf_a),   32'(e.unf));
        check("af_a",      32'(af_a),    32'(e.cnt >= 3));
        check("ae_a",      32'(ae_a),    32'(e.cnt <= 1));
        check("af_b",      32'(af_b),    32'(e.cnt >= 2));
        check("ae_b",      32'(ae_b),    32'(e.cnt <= 2));
        if (e.pchk) check("rd_data", 32'(rd_data), 32'(e.pdata));
      end
    end
  end

  // Reference model state
  logic [7:0] mq[$];
  int  m_wp = 0, m_rp = 0;
  bit  m_ovf = 0, m_unf = 0, m_valid = 0;

  task automatic cycle(input bit rn, input bit cl, input bit pu, input bit po,
                       input logic [7:0] d);
    exp_t e;
    int   n;
    bit   pu_ok, po_ok;
    @(posedge clk);
    #1;
    reset_n = rn; clr = cl; push = pu; pop = po; wr_data = d;
    n = mq.size();
    pu_ok = pu && n < 4 && rn && !cl;
    po_ok = po && n > 0 && rn && !cl;
    e.chk   = m_valid;
    e.pchk  = po_ok;
    e.pdata = (n > 0) ? mq[0] : 8'h00;
    e.wr_en = pu_ok;
    e.wa    = 2'(m_wp);
    e.ra    = 2'(m_rp);
    e.cnt   = n;
    e.full  = (n == 4);
    e.empty = (n == 0);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    sb.push_back(e);
    if (!rn || cl) begin
      mq.delete();
      m_wp = 0; m_rp = 0; m_ovf = 0; m_unf = 0; m_valid = 1;
    end else begin
      if (pu && n == 4) m_ovf = 1;
      if (po && n == 0) m_unf = 1;
      if (po_ok) begin
        void'(mq.pop_front());
        m_rp = (m_rp + 1) % 4;
      end
      if (pu_ok) begin
        mq.push_back(d);
        m_wp = (m_wp + 1) % 4;
      end
    end
  endtask

  task automatic do_push(input logic [7:0] d); cycle(1, 0, 1, 0, d); endtask
  task automatic do_pop();                     cycle(1, 0, 0, 1, 8'h00); endtask
  task automatic do_both(input logic [7:0] d); cycle(1, 0, 1, 1, d); endtask
  task automatic idle();                       cycle(1, 0, 0, 0, 8'h00); endtask

  initial begin
    reset_n = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; wr_data = '0;
    cycle(0, 0, 0, 0, 8'h00);
    cycle(0, 0, 1, 1, 8'h99);
    idle();
    // fill, overflow, drain, underflow
    do_push(8'h11); do_push(8'h22); do_push(8'h33); do_push(8'h44);
    do_push(8'h55); idle();
    repeat (4) do_pop();
    do_pop(); idle();
    // steady-state push+pop at count 2
    cycle(0, 0, 0, 0, 8'h00);
    do_push(8'h01); do_push(8'h02);
    for (int i = 0; i < 6; i++) do_both(8'(8'h10 + i));
    repeat (2) do_pop();
    // full push+pop, then empty push+pop
    for (int i = 0; i < 4; i++) do_push(8'(8'h20 + i));
    do_both(8'h77); idle();
    repeat (3) do_pop();
    do_both(8'h66); idle(); do_pop();
    // clr with push at count 3 and overflow set
    for (int i = 0; i < 5; i++) do_push(8'(8'h30 + i));
    do_pop();
    cycle(1, 1, 1, 0, 8'hEE); idle();
    // reset mid-fill, then A5 round trip
    do_push(8'h40); do_push(8'h41);
    cycle(0, 0, 1, 0, 8'hEF); idle();
    do_push(8'hA5); do_pop(); idle();
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      bit rn, cl;
      rn = ($urandom_range(0, 199) != 0);
      cl = ($urandom_range(0, 99) == 0);
      cycle(rn, cl, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
            8'($urandom));
    end
    idle();
    begin
      int budget = 10;
      while (sb.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (sb.size() > 0) begin
        miscompares++;
        $display("FAIL drain: got %0d pending records expected 0", sb.size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Pointer and status controller for a circular FIFO built around the team's register file (reg_file). It sits directly upstream of reg_file and drives its wr_en, wr_addr and rd_addr from producer push / consumer pop requests. It reports full, empty, almost-full, almost-empty, occupancy count and sticky overflow/underflow errors. A separate fifo wrapper instantiates fifo_ctrl together with reg_file; head data is reg_file's combinational rd_data.

Parameters:
ADDR_WIDTH, 2, address bits; DEPTH = 2**ADDR_WIDTH entries; must match reg_file ADDR_WIDTH.
AF_LEVEL, 2**ADDR_WIDTH-1, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  synchronous active-low reset.
clr  in  1  synchronous flush; same effect as reset; reset_n has priority.
push  in  1  producer write request.
pop  in  1  consumer read request.
wr_en  out  1  reg_file write enable; combinational, push & accepted.
wr_addr  out  ADDR_WIDTH  reg_file write address = write pointer.
rd_addr  out  ADDR_WIDTH  reg_file read address = read pointer (head entry).
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count >= AF_LEVEL.
almost_empty  out  1  count <= AE_LEVEL.
count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH.
overflow  out  1  sticky; set on a rejected push.
underflow  out  1  sticky; set on a rejected pop.

Behaviour:
- One clock; reset is synchronous and active-low (reset_n, sampled on rising clk).
- Reset or clr: wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0. Status outputs therefore read empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0), wr_en=0.
- State registers: wr_ptr, rd_ptr, count, overflow, underflow. All other outputs decode combinationally from these registers, except wr_en, which also depends on push.
- Acceptance is decided combinationally from the current count:
  - push_ok = push & ~full;
  - pop_ok = pop & ~empty.
- wr_en = push_ok. A push that arrives while full never drives wr_en, so stored data is never corrupted.
- On each rising edge when not in reset or clr:
  - push_ok: wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
  - pop_ok: rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
  - count: +1 if push_ok only; -1 if pop_ok only; unchanged if both or neither.
  - push & full: overflow <= 1. pop & empty: underflow <= 1. Both flags hold until reset or clr.
- Simultaneous push and pop:
  - count in 1..DEPTH-1: both accepted; pointers advance, count holds.
  - full: pop accepted, push rejected; overflow set, count -> DEPTH-1.
  - empty: push accepted, pop rejected; underflow set, count -> 1.
- Latency:
  - A pushed word is visible at the head one cycle after the push edge, when the FIFO was empty.
  - A pop consumes the head word the consumer sampled in the pop cycle.
  - Status outputs reflect an operation immediately after the edge that performs it.
- Pointer wrap: DEPTH-1 -> 0. Count uses ADDR_WIDTH+1 bits, so DEPTH is representable. full and empty derive from count, never from pointer equality.
- Reset or clr in the middle of any sequence discards all contents in that cycle. A push or pop in the same cycle is ignored; wr_en is forced to 0 while reset_n=0 or clr=1.

Decomposition:
- No shared package is needed; DEPTH is a localparam derived from ADDR_WIDTH.
- One natural sub-module, wrap_ptr: a parameterised modulo-DEPTH pointer register with clk, reset_n, clr and inc inputs. It is instantiated twice, for wr_ptr and rd_ptr.
- The count, status and error logic stay in fifo_ctrl.

Test Plan:
- Fill (bench instantiates fifo_ctrl + reg_file, DEPTH=4, DATA_WIDTH=8): after reset, push 0x11,0x22,0x33,0x44 on 4 consecutive cycles -> count 1,2,3,4; almost_full at count 3; full=1 after the 4th edge; wr_addr wraps to 0.
- Overflow: push 0x55 while full -> wr_en=0, count stays 4, overflow=1 and stays set; the following drain reads 0x11,0x22,0x33,0x44 only.
- Drain and underflow: pop 4 times -> rd_data 0x11,0x22,0x33,0x44 in order; empty=1; rd_addr wraps to 0. A 5th pop gives underflow=1 and count stays 0.
- Simultaneous: with count=2, push and pop together for 6 cycles -> count holds at 2, both pointers wrap, data stays in order. When full, push and pop together -> count 3, overflow=1. When empty, push and pop together -> count 1, underflow=1.
- Reset and clr: with count=3 and overflow=1, assert clr for one cycle while push=1 -> wr_en=0, count=0, empty=1, overflow=0. Repeat with reset_n=0 mid-fill -> same result; a following push of 0xA5 reads back 0xA5.
- Thresholds: set AF_LEVEL=2 and AE_LEVEL=2 -> almost_full toggles exactly at count 2 rising and falling; almost_empty is high for counts 0..2.
